// File: rtl/anabellek_hakem_pkg.sv
// anabellek_hakem shared types and constants.
// Arbiter states, arbitration modes and the timeout error word.
package anabellek_hakem_pkg;

  typedef enum logic [1:0] {
    BOSTA = 2'd0,
    ISTEK = 2'd1,
    TAMAM = 2'd2
  } durum_t;

  localparam int MOD_SABIT = 0;
  localparam int MOD_DONEL = 1;

  localparam logic [31:0] HATA_VERI = 32'hDEADBEEF;

  // Width able to hold 0..n-1, never below one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/anabellek_hakem_oncelik_secici.sv
// Combinational grant selector shared by fixed-priority and round-robin.
// Round-robin starts scanning just after the last completed requester.
module oncelik_secici
  import anabellek_hakem_pkg::*;
#(
  parameter int KANAL_S = 3,
  parameter int IDX_W   = 2
) (
  input  logic [KANAL_S-1:0] i_istek,
  input  logic [IDX_W-1:0]   i_son,
  input  logic               i_mod,
  output logic [KANAL_S-1:0] o_grant,
  output logic [IDX_W-1:0]   o_idx
);

  logic             w_bul;
  logic             w_donel;
  int               w_j;
  logic [IDX_W-1:0] w_i;

  assign w_donel = (i_mod == 1'(MOD_DONEL));

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_bul   = 1'b0;
    w_j     = 0;
    w_i     = '0;
    for (int k = 0; k < KANAL_S; k++) begin
      w_j = w_donel ? (int'(i_son) + 1 + k) : k;
      if (w_j >= KANAL_S) begin
        w_j = w_j - KANAL_S;
      end
      w_i = IDX_W'(w_j);
      if (!w_bul && i_istek[w_i]) begin
        w_bul      = 1'b1;
        o_grant[w_i] = 1'b1;
        o_idx      = w_i;
      end
    end
  end

endmodule

// File: rtl/anabellek_hakem.sv
// N-to-1 iomem arbiter with fixed/round-robin grant and optional timeout.
// All outputs are registered; one transaction in flight at a time.
module anabellek_hakem
  import anabellek_hakem_pkg::*;
#(
  parameter int KANAL_S     = 3,
  parameter int ADR_W       = 32,
  parameter int VERI_W      = 32,
  parameter int MOD         = 0,
  parameter int ZAMAN_ASIMI = 0
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [KANAL_S-1:0]          ist_valid_i,
  input  logic [KANAL_S*VERI_W/8-1:0] ist_wstrb_i,
  input  logic [KANAL_S*ADR_W-1:0]    ist_addr_i,
  input  logic [KANAL_S*VERI_W-1:0]   ist_wdata_i,
  output logic [KANAL_S-1:0]          ist_ready_o,
  output logic [VERI_W-1:0]           ist_rdata_o,
  output logic [KANAL_S-1:0]          ist_hata_o,
  output logic                        iomem_valid_o,
  input  logic                        iomem_ready_i,
  output logic [VERI_W/8-1:0]         iomem_wstrb_o,
  output logic [ADR_W-1:0]            iomem_addr_o,
  output logic [VERI_W-1:0]           iomem_wdata_o,
  input  logic [VERI_W-1:0]           iomem_rdata_i
);

  localparam int IDX_W = idx_w(KANAL_S);
  localparam int SB_W  = VERI_W / 8;
  localparam int SAY_W = idx_w(ZAMAN_ASIMI);

  localparam logic [VERI_W-1:0] HATA_W  = VERI_W'(HATA_VERI);
  localparam logic [SAY_W-1:0]  SAY_SON = SAY_W'(ZAMAN_ASIMI - 1);
  localparam logic [IDX_W-1:0]  SON_RST = IDX_W'(KANAL_S - 1);

  durum_t             r_durum, w_durum;
  logic [SAY_W-1:0]   r_say,   w_say;
  logic [IDX_W-1:0]   r_son,   w_son;
  logic [IDX_W-1:0]   r_g,     w_g;
  logic [KANAL_S-1:0] r_grant, w_grant;
  logic [KANAL_S-1:0] r_rdy,   w_rdy;
  logic [KANAL_S-1:0] r_hata,  w_hata;
  logic               r_mv,    w_mv;
  logic [SB_W-1:0]    r_ws,    w_ws;
  logic [ADR_W-1:0]   r_ad,    w_ad;
  logic [VERI_W-1:0]  r_wd,    w_wd;
  logic [VERI_W-1:0]  r_rd,    w_rd;

  logic [KANAL_S-1:0] w_sec_grant;
  logic [IDX_W-1:0]   w_sec_idx;
  logic               w_zaman;

  oncelik_secici #(
    .KANAL_S (KANAL_S),
    .IDX_W   (IDX_W)
  ) u_secici (
    .i_istek (ist_valid_i),
    .i_son   (r_son),
    .i_mod   (MOD == MOD_DONEL),
    .o_grant (w_sec_grant),
    .o_idx   (w_sec_idx)
  );

  assign w_zaman = (ZAMAN_ASIMI != 0) && (r_say == SAY_SON);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_durum <= BOSTA;
      r_say   <= '0;
      r_son   <= SON_RST;
      r_g     <= '0;
      r_grant <= '0;
      r_rdy   <= '0;
      r_hata  <= '0;
      r_mv    <= 1'b0;
      r_ws    <= '0;
      r_ad    <= '0;
      r_wd    <= '0;
      r_rd    <= '0;
    end else begin
      r_durum <= w_durum;
      r_say   <= w_say;
      r_son   <= w_son;
      r_g     <= w_g;
      r_grant <= w_grant;
      r_rdy   <= w_rdy;
      r_hata  <= w_hata;
      r_mv    <= w_mv;
      r_ws    <= w_ws;
      r_ad    <= w_ad;
      r_wd    <= w_wd;
      r_rd    <= w_rd;
    end
  end

  always_comb begin
    w_durum = r_durum;
    w_say   = r_say;
    w_son   = r_son;
    w_g     = r_g;
    w_grant = r_grant;
    w_mv    = r_mv;
    w_ws    = r_ws;
    w_ad    = r_ad;
    w_wd    = r_wd;
    w_rd    = r_rd;
    w_rdy   = '0;
    w_hata  = '0;
    unique case (r_durum)
      BOSTA: begin
        if (|ist_valid_i) begin
          w_g     = w_sec_idx;
          w_grant = w_sec_grant;
          w_ad    = ist_addr_i[w_sec_idx*ADR_W +: ADR_W];
          w_ws    = ist_wstrb_i[w_sec_idx*SB_W +: SB_W];
          w_wd    = ist_wdata_i[w_sec_idx*VERI_W +: VERI_W];
          w_mv    = 1'b1;
          w_durum = ISTEK;
        end
      end
      ISTEK: begin
        w_say = r_say + 1'b1;
        // Downstream completion beats a timeout landing on the same cycle.
        if (iomem_ready_i) begin
          w_mv    = 1'b0;
          w_rd    = iomem_rdata_i;
          w_rdy   = r_grant;
          w_son   = r_g;
          w_durum = TAMAM;
        end else if (w_zaman) begin
          w_mv    = 1'b0;
          w_rd    = HATA_W;
          w_rdy   = r_grant;
          w_hata  = r_grant;
          w_son   = r_g;
          w_durum = TAMAM;
        end
      end
      TAMAM: begin
        w_say   = '0;
        w_durum = BOSTA;
      end
      default: begin
        w_durum = BOSTA;
      end
    endcase
  end

  assign ist_ready_o   = r_rdy;
  assign ist_hata_o    = r_hata;
  assign ist_rdata_o   = r_rd;
  assign iomem_valid_o = r_mv;
  assign iomem_wstrb_o = r_ws;
  assign iomem_addr_o  = r_ad;
  assign iomem_wdata_o = r_wd;

endmodule

// File: tb/tb_anabellek_hakem.sv
// Scoreboard bench for anabellek_hakem: u_a fixed-priority with timeout,
// u_b round-robin without timeout.
module tb_anabellek_hakem;

  typedef struct {
    int          cyc;
    logic [31:0] ad;
    logic [3:0]  ws;
    logic [31:0] wd;
  } req_t;

  typedef struct {
    int          cyc;
    logic [2:0]  rdy;
    logic [2:0]  err;
    logic [31:0] rd;
  } rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_seen = 1'b0;
  logic done = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;
  int   t0;

  logic [2:0]  a_val, a_rdy, a_err, b_val, b_rdy, b_err;
  logic [11:0] a_ws, b_ws;
  logic [95:0] a_ad, a_wd, b_ad, b_wd;
  logic [31:0] a_rd, b_rd;
  logic        a_mv, a_mr, b_mv, b_mr;
  logic [3:0]  a_mws, b_mws;
  logic [31:0] a_mad, a_mwd, a_mrd;
  logic [31:0] b_mad, b_mwd, b_mrd;

  req_t qa_req[$], qb_req[$];
  rsp_t qa_rsp[$], qb_rsp[$];
  req_t er, la, lb;
  rsp_t es;
  logic a_pv = 1'b0;
  logic b_pv = 1'b0;

  logic [31:0] tab [3] = '{32'hB000_0100, 32'hB000_0200, 32'hB000_0300};
  int          ord [5] = '{0, 1, 2, 0, 1};

  anabellek_hakem #(
    .KANAL_S(3), .ADR_W(32), .VERI_W(32), .MOD(0), .ZAMAN_ASIMI(8)
  ) u_a (
    .clk_i(clk), .rst_i(rst),
    .ist_valid_i(a_val), .ist_wstrb_i(a_ws),
    .ist_addr_i(a_ad), .ist_wdata_i(a_wd),
    .ist_ready_o(a_rdy), .ist_rdata_o(a_rd), .ist_hata_o(a_err),
    .iomem_valid_o(a_mv), .iomem_ready_i(a_mr),
    .iomem_wstrb_o(a_mws), .iomem_addr_o(a_mad),
    .iomem_wdata_o(a_mwd), .iomem_rdata_i(a_mrd)
  );

  anabellek_hakem #(
    .KANAL_S(3), .ADR_W(32), .VERI_W(32), .MOD(1), .ZAMAN_ASIMI(0)
  ) u_b (
    .clk_i(clk), .rst_i(rst),
    .ist_valid_i(b_val), .ist_wstrb_i(b_ws),
    .ist_addr_i(b_ad), .ist_wdata_i(b_wd),
    .ist_ready_o(b_rdy), .ist_rdata_o(b_rd), .ist_hata_o(b_err),
    .iomem_valid_o(b_mv), .iomem_ready_i(b_mr),
    .iomem_wstrb_o(b_mws), .iomem_addr_o(b_mad),
    .iomem_wdata_o(b_mwd), .iomem_rdata_i(b_mrd)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= rst;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_req(input bit b, input int c, input logic [31:0] ad,
                         input logic [3:0] ws, input logic [31:0] wd);
    req_t r;
    r.cyc = c; r.ad = ad; r.ws = ws; r.wd = wd;
    if (b) qb_req.push_back(r);
    else   qa_req.push_back(r);
  endtask

  task automatic exp_rsp(input bit b, input int c, input logic [2:0] rdy,
                         input logic [2:0] err, input logic [31:0] rd);
    rsp_t r;
    r.cyc = c; r.rdy = rdy; r.err = err; r.rd = rd;
    if (b) qb_rsp.push_back(r);
    else   qa_rsp.push_back(r);
  endtask

  task automatic seta(input int k, input logic [31:0] ad,
                      input logic [3:0] ws, input logic [31:0] wd);
    a_ad[k*32 +: 32] = ad;
    a_ws[k*4 +: 4]   = ws;
    a_wd[k*32 +: 32] = wd;
  endtask

  task automatic setb(input int k, input logic [31:0] ad,
                      input logic [3:0] ws, input logic [31:0] wd);
    b_ad[k*32 +: 32] = ad;
    b_ws[k*4 +: 4]   = ws;
    b_wd[k*32 +: 32] = wd;
  endtask

  // Monitor: pops expected requests/responses as the DUTs present them.
  always @(negedge clk) begin
    if (rst_seen) begin
      chk("a_rst_zero",
          32'(|{a_rdy, a_rd, a_err, a_mv, a_mws, a_mad, a_mwd}), 0);
      chk("b_rst_zero",
          32'(|{b_rdy, b_rd, b_err, b_mv, b_mws, b_mad, b_mwd}), 0);
    end else if (cyc > 0) begin
      if (a_mv && !a_pv) begin
        if (qa_req.size() == 0) chk("a_req_extra", 1, 0);
        else begin
          er = qa_req.pop_front();
          chk("a_req_cyc", cyc, er.cyc);
          chk("a_req_addr", a_mad, er.ad);
          chk("a_req_wstrb", 32'(a_mws), 32'(er.ws));
          chk("a_req_wdata", a_mwd, er.wd);
          la = er;
        end
      end else if (a_mv) begin
        chk("a_hold_addr", a_mad, la.ad);
        chk("a_hold_wstrb", 32'(a_mws), 32'(la.ws));
        chk("a_hold_wdata", a_mwd, la.wd);
      end
      if (a_rdy != 3'b000) begin
        if (qa_rsp.size() == 0) chk("a_rsp_extra", 32'(a_rdy), 0);
        else begin
          es = qa_rsp.pop_front();
          chk("a_rsp_cyc", cyc, es.cyc);
          chk("a_rsp_ready", 32'(a_rdy), 32'(es.rdy));
          chk("a_rsp_hata", 32'(a_err), 32'(es.err));
          chk("a_rsp_rdata", a_rd, es.rd);
          chk("a_rsp_mv_low", 32'(a_mv), 0);
        end
      end else if (a_err != 3'b000) begin
        chk("a_hata_alone", 32'(a_err), 0);
      end
      if (b_mv && !b_pv) begin
        if (qb_req.size() == 0) chk("b_req_extra", 1, 0);
        else begin
          er = qb_req.pop_front();
          chk("b_req_cyc", cyc, er.cyc);
          chk("b_req_addr", b_mad, er.ad);
          chk("b_req_wstrb", 32'(b_mws), 32'(er.ws));
          chk("b_req_wdata", b_mwd, er.wd);
          lb = er;
        end
      end else if (b_mv) begin
        chk("b_hold_addr", b_mad, lb.ad);
      end
      if (b_rdy != 3'b000) begin
        if (qb_rsp.size() == 0) chk("b_rsp_extra", 32'(b_rdy), 0);
        else begin
          es = qb_rsp.pop_front();
          chk("b_rsp_cyc", cyc, es.cyc);
          chk("b_rsp_ready", 32'(b_rdy), 32'(es.rdy));
          chk("b_rsp_hata", 32'(b_err), 32'(es.err));
          chk("b_rsp_rdata", b_rd, es.rd);
        end
      end else if (b_err != 3'b000) begin
        chk("b_hata_alone", 32'(b_err), 0);
      end
    end
    a_pv <= a_mv;
    b_pv <= b_mv;
    if (done) begin
      chk("a_queue_left", qa_req.size() + qa_rsp.size(), 0);
      chk("b_queue_left", qb_req.size() + qb_rsp.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
    end
  end

  initial begin
    a_val = '0; a_ws = '0; a_ad = '0; a_wd = '0; a_mr = 0; a_mrd = '0;
    b_val = '0; b_ws = '0; b_ad = '0; b_wd = '0; b_mr = 0; b_mrd = '0;
    repeat (3) step();
    rst = 1'b0;
    step(); step();

    // Fixed priority: req0 and req2 together, req0 first.
    t0 = cyc;
    seta(0, 32'h1000_0000, 4'h0, 32'h0);
    seta(2, 32'h2000_0008, 4'h0, 32'h0);
    a_val = 3'b101;
    exp_req(0, t0 + 1, 32'h1000_0000, 4'h0, 32'h0);
    exp_rsp(0, t0 + 4, 3'b001, 3'b000, 32'h1111_0000);
    exp_req(0, t0 + 6, 32'h2000_0008, 4'h0, 32'h0);
    exp_rsp(0, t0 + 7, 3'b100, 3'b000, 32'h2222_2222);
    step(); step(); step();
    a_mr = 1; a_mrd = 32'h1111_0000; step();
    a_mr = 0; step();
    a_val = 3'b100; step();
    a_mr = 1; a_mrd = 32'h2222_2222; step();
    a_mr = 0; step();
    a_val = 3'b000; step(); step();

    // Write pass-through on req1.
    t0 = cyc;
    seta(1, 32'h4000_0010, 4'b0011, 32'h1234_5678);
    a_val = 3'b010;
    exp_req(0, t0 + 1, 32'h4000_0010, 4'b0011, 32'h1234_5678);
    exp_rsp(0, t0 + 2, 3'b010, 3'b000, 32'hA5A5_5A5A);
    step();
    a_mr = 1; a_mrd = 32'hA5A5_5A5A; step();
    a_mr = 0; step();
    a_val = 3'b000; step(); step();

    // Timeout: downstream never answers.
    t0 = cyc;
    seta(0, 32'h3000_0004, 4'h0, 32'h0);
    a_mrd = 32'h5555_AAAA;
    a_val = 3'b001;
    exp_req(0, t0 + 1, 32'h3000_0004, 4'h0, 32'h0);
    exp_rsp(0, t0 + 9, 3'b001, 3'b001, 32'hDEAD_BEEF);
    repeat (10) step();
    a_val = 3'b000; step(); step();

    // Ready on the last ISTEK cycle wins over the timeout.
    t0 = cyc;
    seta(2, 32'h5000_000C, 4'h0, 32'h0);
    a_val = 3'b100;
    exp_req(0, t0 + 1, 32'h5000_000C, 4'h0, 32'h0);
    exp_rsp(0, t0 + 9, 3'b100, 3'b000, 32'h0BAD_F00D);
    repeat (8) step();
    a_mr = 1; a_mrd = 32'h0BAD_F00D; step();
    a_mr = 0; step();
    a_val = 3'b000; step(); step();

    // Round-robin with all requesters busy.
    for (int g = 0; g < 3; g++) setb(g, tab[g], 4'h0, 32'h0);
    t0 = cyc;
    b_val = 3'b111;
    for (int k = 0; k < 5; k++) begin
      exp_req(1, t0 + 1 + 3 * k, tab[ord[k]], 4'h0, 32'h0);
      exp_rsp(1, t0 + 2 + 3 * k, 3'b001 << ord[k], 3'b000,
              32'hC000_0000 + 32'(k));
    end
    for (int c = 0; c < 16; c++) begin
      if (c % 3 == 1 && c <= 13) begin
        b_mr = 1; b_mrd = 32'hC000_0000 + 32'((c - 1) / 3);
      end else begin
        b_mr = 0;
      end
      if (c == 15) b_val = 3'b000;
      step();
    end
    step();

    // Reset while req2 is in ISTEK; afterwards req0 is granted first.
    t0 = cyc;
    b_val = 3'b111;
    exp_req(1, t0 + 1, tab[2], 4'h0, 32'h0);
    exp_req(1, t0 + 4, tab[0], 4'h0, 32'h0);
    exp_rsp(1, t0 + 5, 3'b001, 3'b000, 32'h7777_0000);
    step(); step();
    rst = 1'b1; step();
    rst = 1'b0; step();
    b_mr = 1; b_mrd = 32'h7777_0000; step();
    b_mr = 0; step();
    b_val = 3'b000; step(); step();

    done = 1'b1;
    step(); step();
  end

endmodule
